pair_diff_avg: RTL and testbench

PAIR_DIFF_AVG -- requirements
Module: pair_diff_avg

---
 rtl/pair_diff_avg.sv | 165 ++++++++++++++++
 tb/tb_pair_diff_avg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_diff_avg.sv
// Pairs consecutive samples (A then B), forms a biased signed difference,
// averages 2^LOG2_N differences and emits a clamped or wrapped result.
module pair_diff_avg #(
  parameter int unsigned W      = 20,
  parameter logic [W-1:0] OFFSET = W'(20'h007F0),
  parameter int unsigned LOG2_N = 0,
  parameter bit          SAT    = 1'b1,
  parameter int unsigned SKIP   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dval,
  input  logic [W-1:0] mlt,
  input  logic         phase,
  input  logic         sync,
  output logic [W-1:0] out_data,
  output logic         o_dval,
  output logic         o_ovf
);

  localparam int unsigned DW   = W + 2;
  localparam int unsigned AccW = DW + LOG2_N;
  localparam int unsigned CntW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << LOG2_N) - 1);
  localparam logic [3:0] SkipInit = 4'(SKIP);
  localparam logic signed [AccW-1:0] MaxS = AccW'({W{1'b1}});

  typedef enum logic [0:0] {StIdleA, StHaveA} state_e;

  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic ph_q, ph_d;
  logic pair_q, pair_d;

  logic signed [DW-1:0] a_x, b_x, off_x, d_calc, d_q;
  logic dv_q;

  logic signed [AccW-1:0] acc_q, d_ext, sum, r;
  logic [CntW-1:0] cnt_q;
  logic [3:0] skip_q;
  logic is_neg, is_big, ovf;
  logic [W-1:0] res;

  // Pairing next-state: sync drops any held A before a same-cycle dval is taken as A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ph_d    = ph_q;
    pair_d  = 1'b0;
    if (sync) begin
      state_d = StIdleA;
      if (dval) begin
        a_d     = mlt;
        state_d = StHaveA;
      end
    end else if (dval) begin
      case (state_q)
        StIdleA: begin
          a_d     = mlt;
          state_d = StHaveA;
        end
        StHaveA: begin
          b_d     = mlt;
          ph_d    = phase;
          pair_d  = 1'b1;
          state_d = StIdleA;
        end
        default: state_d = StIdleA;
      endcase
    end
  end

  // Pairing state and sample registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdleA;
      a_q     <= '0;
      b_q     <= '0;
      ph_q    <= 1'b0;
      pair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ph_q    <= ph_d;
      pair_q  <= pair_d;
    end
  end

  // Biased difference; W+2 signed bits hold every possible value without overflow.
  always_comb begin
    a_x    = signed'({2'b00, a_q});
    b_x    = signed'({2'b00, b_q});
    off_x  = signed'({2'b00, OFFSET});
    d_calc = (ph_q ? (a_x - b_x) : (b_x - a_x)) + off_x;
  end

  // Difference stage; a sync squashes a pair still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q  <= '0;
      dv_q <= 1'b0;
    end else begin
      dv_q <= pair_q & ~sync;
      if (pair_q) begin
        d_q <= d_calc;
      end
    end
  end

  // Average of the completed group, then clamp or wrap into W bits.
  always_comb begin
    d_ext  = AccW'(d_q);
    sum    = acc_q + d_ext;
    r      = sum >>> LOG2_N;
    is_neg = r[AccW-1];
    is_big = !is_neg && (r > MaxS);
    ovf    = is_neg | is_big;
    res    = r[W-1:0];
    if (SAT) begin
      if (is_neg) begin
        res = '0;
      end else if (is_big) begin
        res = '1;
      end
    end
  end

  // Accumulator, group counter, skip counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      skip_q   <= SkipInit;
      out_data <= '0;
      o_dval   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_dval <= 1'b0;
      o_ovf  <= 1'b0;
      if (sync) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        skip_q <= SkipInit;
      end else if (dv_q) begin
        if (cnt_q == CntLast) begin
          acc_q <= '0;
          cnt_q <= '0;
          if (skip_q != 4'd0) begin
            skip_q <= skip_q - 4'd1;
          end else begin
            out_data <= res;
            o_dval   <= 1'b1;
            o_ovf    <= ovf;
          end
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pair_diff_avg.sv
// Self-checking bench: three configurations driven by one input stream,
// compared each cycle against a queue-based arithmetic model.
module tb_pair_diff_avg;

  localparam int W = 20;
  localparam longint MaxV = (longint'(1) << W) - 1;
  localparam longint Off = 64'h7F0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dval = 1'b0;
  logic phase = 1'b0;
  logic sync = 1'b0;
  logic [W-1:0] mlt = '0;

  logic [W-1:0] out0, out1, out2;
  logic dv0, dv1, dv2, ov0, ov1, ov2;

  always #5 clk = ~clk;

  // k0: single pair, saturate, no skip
  pair_diff_avg #(.W(W), .LOG2_N(0), .SAT(1'b1), .SKIP(0)) u_k0 (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .phase(phase), .sync(sync),
    .out_data(out0), .o_dval(dv0), .o_ovf(ov0));
  // k1: average of four, saturate, no skip
  pair_diff_avg #(.W(W), .LOG2_N(2), .SAT(1'b1), .SKIP(0)) u_k1 (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .phase(phase), .sync(sync),
    .out_data(out1), .o_dval(dv1), .o_ovf(ov1));
  // k2: single pair, wrap, skip one
  pair_diff_avg #(.W(W), .LOG2_N(0), .SAT(1'b0), .SKIP(1)) u_k2 (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .phase(phase), .sync(sync),
    .out_data(out2), .o_dval(dv2), .o_ovf(ov2));

  int errors = 0;
  int checks = 0;

  int cfg_l[3]    = '{0, 2, 0};
  int cfg_skip[3] = '{0, 0, 1};
  bit cfg_sat[3]  = '{1'b1, 1'b1, 1'b0};

  longint acc[3];
  int cnt[3];
  int skip[3];
  logic [W-1:0] e_out[3];
  bit e_dv[3];
  bit e_ovf[3];

  int cyc = 0;
  bit have_a = 1'b0;
  longint a_val = 0;
  int pend_t[$];
  longint pend_d[$];

  task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0b want %0b", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    pend_t.delete();
    pend_d.delete();
    have_a = 1'b0;
    a_val = 0;
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0;
      cnt[k] = 0;
      skip[k] = cfg_skip[k];
      e_out[k] = '0;
      e_dv[k] = 1'b0;
      e_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void avg_add(input int k, input longint d);
    longint r;
    acc[k] += d;
    cnt[k]++;
    if (cnt[k] == (1 << cfg_l[k])) begin
      r = acc[k] >>> cfg_l[k];
      acc[k] = 0;
      cnt[k] = 0;
      if (skip[k] > 0) begin
        skip[k]--;
      end else begin
        e_dv[k] = 1'b1;
        e_ovf[k] = (r < 0) || (r > MaxV);
        if (cfg_sat[k] && r < 0) e_out[k] = '0;
        else if (cfg_sat[k] && r > MaxV) e_out[k] = '1;
        else e_out[k] = r[W-1:0];
      end
    end
  endfunction

  // One rising edge of the reference behaviour, using the inputs the DUT sees.
  function automatic void model_edge();
    longint d;
    longint m;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      e_dv[k] = 1'b0;
      e_ovf[k] = 1'b0;
    end
    if (sync) begin
      pend_t.delete();
      pend_d.delete();
      have_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
        acc[k] = 0;
        cnt[k] = 0;
        skip[k] = cfg_skip[k];
      end
    end else begin
      while (pend_t.size() > 0 && pend_t[0] == cyc) begin
        d = pend_d.pop_front();
        void'(pend_t.pop_front());
        for (int k = 0; k < 3; k++) avg_add(k, d);
      end
    end
    if (dval) begin
      m = longint'(mlt);
      if (!have_a) begin
        a_val = m;
        have_a = 1'b1;
      end else begin
        d = (phase ? (a_val - m) : (m - a_val)) + Off;
        pend_t.push_back(cyc + 2);
        pend_d.push_back(d);
        have_a = 1'b0;
      end
    end
  endfunction

  task automatic check_model();
    chk_w("k0_out", out0, e_out[0]);
    chk_b("k0_dval", dv0, e_dv[0]);
    chk_b("k0_ovf", ov0, e_ovf[0]);
    chk_w("k1_out", out1, e_out[1]);
    chk_b("k1_dval", dv1, e_dv[1]);
    chk_b("k1_ovf", ov1, e_ovf[1]);
    chk_w("k2_out", out2, e_out[2]);
    chk_b("k2_dval", dv2, e_dv[2]);
    chk_b("k2_ovf", ov2, e_ovf[2]);
  endtask

  // Drive at a falling edge, advance the model at the rising edge, check at the next fall.
  task automatic step(input bit dv, input logic [W-1:0] m, input bit ph, input bit sy);
    dval = dv;
    mlt = m;
    phase = ph;
    sync = sy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk_w({tag, "_out0"}, out0, '0);
    chk_w({tag, "_out1"}, out1, '0);
    chk_w({tag, "_out2"}, out2, '0);
    chk_b({tag, "_dv"}, dv0 | dv1 | dv2, 1'b0);
    chk_b({tag, "_ovf"}, ov0 | ov1 | ov2, 1'b0);
  endtask

  initial begin
    logic [W-1:0] avg_exp;
    logic [W-1:0] rm;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Basic pair, phase=1: A-B+offset
    step(1'b1, 20'h00100, 1'b0, 1'b0);
    step(1'b1, 20'h00050, 1'b1, 1'b0);
    chk_b("t1_early", dv0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_w("t1_out", out0, 20'h008A0);
    chk_b("t1_dval", dv0, 1'b1);

    // phase=0, with phase toggled on the A cycle only
    step(1'b1, 20'h00100, 1'b1, 1'b0);
    step(1'b1, 20'h00050, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_w("t2_out", out0, 20'h00740);
    chk_b("t2_dval", dv0, 1'b1);

    // Four-pair average on k1
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 20'h00000, 1'b0, 1'b0);
      step(1'b1, W'(20'h10 + 2 * i), 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    avg_exp = W'((20'h800 + 20'h802 + 20'h804 + 20'h806) >> 2);
    chk_w("t3_out", out1, avg_exp);
    chk_b("t3_dval", dv1, 1'b1);

    // Saturation both ways on k0
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 20'h00000, 1'b1, 1'b0);
    step(1'b1, 20'hFFFFF, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_w("t4_lo_out", out0, 20'h00000);
    chk_b("t4_lo_ovf", ov0, 1'b1);
    step(1'b1, 20'hFFFFF, 1'b1, 1'b0);
    step(1'b1, 20'h00000, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_w("t4_hi_out", out0, 20'hFFFFF);
    chk_b("t4_hi_ovf", ov0, 1'b1);

    // Sync realignment and skip on k2
    step(1'b1, 20'h00010, 1'b0, 1'b0);
    step(1'b1, 20'h00020, 1'b0, 1'b1);
    step(1'b1, 20'h00030, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_b("t5_skipped", dv2, 1'b0);
    chk_w("t5_k0_out", out0, 20'h00800);
    step(1'b1, 20'h00040, 1'b0, 1'b0);
    step(1'b1, 20'h00050, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_w("t5_out", out2, 20'h00800);
    chk_b("t5_dval", dv2, 1'b1);

    // Reset between A and B; pairing restarts after release
    step(1'b1, 20'h00123, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("t6_async");
    step(1'b1, 20'h00055, 1'b1, 1'b0);
    step(1'b1, 20'h00066, 1'b1, 1'b0);
    check_all_zero("t6_held");
    rst = 1'b1;
    step(1'b1, 20'h00010, 1'b0, 1'b0);
    step(1'b1, 20'h00020, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_w("t6_out", out0, 20'h00800);
    chk_b("t6_dval", dv0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rm = W'($urandom());
      else rm = W'(20'h00400 + $urandom_range(0, 20'h00FFF));
      step(($urandom_range(0, 9) < 7), rm, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
